udl_count_sequencer: RTL

Controller that sequences an up/down/loadable counter datapath (BITS-wide; Q <= load ? PI : up ? Q+1 : Q-1 every cycle, no enable) through programmed count runs. It accepts a command (start, end, direction, repeat count) over a valid/ready handshake. It drives the counter's load/up/PI inputs and observes its Q. It signals each lap and final completion. Because the counter has no hold input, the sequencer holds the counter by reloading its current value.

---
 rtl/udl_count_sequencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/udl_count_sequencer.sv
// udl_count_sequencer
//   Sequences an external up/down/loadable counter (Q <= load ? PI : up ? Q+1 : Q-1,
//   no enable) through programmed count runs. A command (start, end, direction,
//   repeat count) is taken over a valid/ready handshake. Each run is
//   cmd_reps+1 laps, and each lap counts from start to end. The counter has no
//   enable, so "hold" means reloading its own Q.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_start/end/up/reps     command fields
//   pause, abort              level controls while running
//   cnt_load/cnt_up/cnt_pi    drive the counter; cnt_q observes it
//   busy, lap, done           status: active, per-lap pulse, completion pulse
module udl_count_sequencer #(
  parameter int BITS     = 4,
  parameter int REP_BITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [BITS-1:0]     cmd_start,
  input  logic [BITS-1:0]     cmd_end,
  input  logic                cmd_up,
  input  logic [REP_BITS-1:0] cmd_reps,
  input  logic                pause,
  input  logic                abort,
  output logic                cnt_load,
  output logic                cnt_up,
  output logic [BITS-1:0]     cnt_pi,
  input  logic [BITS-1:0]     cnt_q,
  output logic                busy,
  output logic                lap,
  output logic                done
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t              state, state_nxt;
  logic [BITS-1:0]     start_r, end_r;
  logic                up_r;
  logic [REP_BITS-1:0] rep_r;
  logic                match;
  logic                run_live;  // RUN and not aborting this cycle

  assign match    = (cnt_q == end_r);
  assign run_live = (state == RUN) && !abort;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Next state and counter controls. Default is hold (reload current Q).
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b1;
    cnt_pi    = cnt_q;
    cnt_up    = up_r;
    case (state)
      IDLE: if (cmd_valid) state_nxt = LOAD;
      LOAD: begin
        if (abort) state_nxt = IDLE;
        else begin
          cnt_pi    = start_r;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) state_nxt = IDLE;
        else if (match) begin
          // End of lap wins over pause: either restart the lap or finish.
          if (rep_r != '0) cnt_pi = start_r;
          else             state_nxt = DONE;
        end
        else if (!pause) cnt_load = 1'b0;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      start_r <= '0;
      end_r   <= '0;
      up_r    <= 1'b0;
      rep_r   <= '0;
      lap     <= 1'b0;
    end else begin
      state <= state_nxt;
      lap   <= run_live && match;
      if (state == IDLE && cmd_valid) begin
        start_r <= cmd_start;
        end_r   <= cmd_end;
        up_r    <= cmd_up;
        rep_r   <= cmd_reps;
      end else if (run_live && match && rep_r != '0) begin
        rep_r <= rep_r - REP_BITS'(1);
      end
    end
  end

endmodule
